mmu_job_sequencer: RTL and testbench

- Command initiator for the 4x4 systolic matrix-multiply unit. It accepts one tile job, reads packed data/weight vectors from the operand buffer, and issues RESET, then TRIGGER/TRIGGER_LAST per k-step, then FORWARD flush commands.
- It then waits for the array to go idle, captures the four result columns, and streams them out as four beats to the write-back path.
- It sits between the layer controller and the MMU, and replaces host-driven command sequencing for plain GEMM tiles.

---
 rtl/mmu_job_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_mmu_job_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_job_sequencer.sv
// Tile-job command sequencer for the 4x4 systolic MMU: issues RESET / TRIGGER / FORWARD
// commands from operand-buffer reads, then captures and streams the four result columns.
module mmu_job_sequencer #(
  parameter int ACLEN        = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int KLEN_W       = 16,
  parameter int ADDR_W       = 12,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [KLEN_W-1:0]       job_k_len,
  input  logic [ADDR_W-1:0]       job_base_addr,
  output logic                    buf_rd_en,
  output logic [ADDR_W-1:0]       buf_rd_addr,
  input  logic [4*DATA_WIDTH-1:0] buf_data_in,
  input  logic [4*DATA_WIDTH-1:0] buf_weight_in,
  output logic                    mmu_cmd_valid,
  output logic [ACLEN:0]          mmu_cmd,
  output logic [4*DATA_WIDTH-1:0] mmu_data_out,
  output logic [4*DATA_WIDTH-1:0] mmu_weight_out,
  input  logic                    mmu_busy,
  input  logic [4*DATA_WIDTH-1:0] rdata_1_in,
  input  logic [4*DATA_WIDTH-1:0] rdata_2_in,
  input  logic [4*DATA_WIDTH-1:0] rdata_3_in,
  input  logic [4*DATA_WIDTH-1:0] rdata_4_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [4*DATA_WIDTH-1:0] res_data,
  output logic [1:0]              res_col,
  output logic                    done,
  output logic                    busy
);

  localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [DCNT_W-1:0] D_ONE  = DCNT_W'(1);
  localparam logic [KLEN_W-1:0] K_ONE  = KLEN_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [ACLEN:0] CMD_RESET    = (ACLEN+1)'(0);
  localparam logic [ACLEN:0] CMD_TRIGGER  = (ACLEN+1)'(1);
  localparam logic [ACLEN:0] CMD_TRIG_LST = (ACLEN+1)'(2);
  localparam logic [ACLEN:0] CMD_FORWARD  = (ACLEN+1)'(8);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_WAIT  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [KLEN_W-1:0]         r_k_len;
  logic [ADDR_W-1:0]         r_base;
  logic [KLEN_W-1:0]         r_kcnt;
  logic [DCNT_W-1:0]         r_dcnt;
  logic [1:0]                r_ccnt;
  logic [4*DATA_WIDTH-1:0]   r_col [0:3];
  logic                      r_done;
  logic [KLEN_W-1:0]         w_kcnt_inc;
  logic                      w_last_k;
  logic [ADDR_W-1:0]         w_feed_addr;

  assign w_kcnt_inc  = r_kcnt + K_ONE;
  assign w_last_k    = (r_kcnt == (r_k_len - K_ONE));
  // k-step addresses wrap naturally in the ADDR_W-bit sum
  assign w_feed_addr = r_base + r_kcnt[ADDR_W-1:0] + A_ONE;
  assign done        = r_done;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job latch, step counters, result capture and completion pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_k_len <= '0;
      r_base  <= '0;
      r_kcnt  <= '0;
      r_dcnt  <= '0;
      r_ccnt  <= 2'd0;
      r_done  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_col[i] <= '0;
      end
    end else begin
      r_done <= (r_state == S_OUT) && res_ready && (r_ccnt == 2'd3);
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_k_len <= job_k_len;
            r_base  <= job_base_addr;
          end
        end
        S_CLR:   r_kcnt <= '0;
        S_FEED: begin
          r_kcnt <= w_kcnt_inc;
          r_dcnt <= '0;
        end
        S_DRAIN: r_dcnt <= r_dcnt + D_ONE;
        S_WAIT: begin
          if (!mmu_busy) begin
            r_col[0] <= rdata_1_in;
            r_col[1] <= rdata_2_in;
            r_col[2] <= rdata_3_in;
            r_col[3] <= rdata_4_in;
            r_ccnt   <= 2'd0;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_ccnt <= r_ccnt + 2'd1;
          end
        end
        default: r_kcnt <= r_kcnt;
      endcase
    end
  end

  // Next-state and combinational command / buffer / result outputs
  always_comb begin
    w_state_nxt    = r_state;
    job_ready      = 1'b0;
    busy           = 1'b1;
    buf_rd_en      = 1'b0;
    buf_rd_addr    = '0;
    mmu_cmd_valid  = 1'b0;
    mmu_cmd        = CMD_RESET;
    mmu_data_out   = '0;
    mmu_weight_out = '0;
    res_valid      = 1'b0;
    res_data       = '0;
    res_col        = 2'd0;
    case (r_state)
      S_IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) w_state_nxt = S_CLR;
        else           w_state_nxt = S_IDLE;
      end
      S_CLR: begin
        mmu_cmd_valid = 1'b1;
        mmu_cmd       = CMD_RESET;
        if (r_k_len != '0) begin
          buf_rd_en   = 1'b1;
          buf_rd_addr = r_base;
          w_state_nxt = S_FEED;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_FEED: begin
        mmu_cmd_valid  = 1'b1;
        mmu_cmd        = w_last_k ? CMD_TRIG_LST : CMD_TRIGGER;
        mmu_data_out   = buf_data_in;
        mmu_weight_out = buf_weight_in;
        if (w_kcnt_inc < r_k_len) begin
          buf_rd_en   = 1'b1;
          buf_rd_addr = w_feed_addr;
        end else begin
          buf_rd_en   = 1'b0;
        end
        if (w_last_k) w_state_nxt = S_DRAIN;
        else          w_state_nxt = S_FEED;
      end
      S_DRAIN: begin
        mmu_cmd_valid = 1'b1;
        mmu_cmd       = CMD_FORWARD;
        if (r_dcnt == D_LAST) w_state_nxt = S_WAIT;
        else                  w_state_nxt = S_DRAIN;
      end
      S_WAIT: begin
        if (!mmu_busy) w_state_nxt = S_OUT;
        else           w_state_nxt = S_WAIT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        res_data  = r_col[r_ccnt];
        res_col   = r_ccnt;
        if (res_ready && (r_ccnt == 2'd3)) w_state_nxt = S_IDLE;
        else                               w_state_nxt = S_OUT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmu_job_sequencer.sv
// Directed self-checking bench for mmu_job_sequencer: cycle-exact command trace,
// result back-pressure, busy wait, K=0, address wrap and mid-job reset.
module tb_mmu_job_sequencer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         job_valid;
  logic         job_ready;
  logic [15:0]  job_k_len;
  logic [11:0]  job_base_addr;
  logic         buf_rd_en;
  logic [11:0]  buf_rd_addr;
  logic [127:0] buf_data_in;
  logic [127:0] buf_weight_in;
  logic         mmu_cmd_valid;
  logic [8:0]   mmu_cmd;
  logic [127:0] mmu_data_out;
  logic [127:0] mmu_weight_out;
  logic         mmu_busy;
  logic [127:0] rdata_1_in, rdata_2_in, rdata_3_in, rdata_4_in;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic [1:0]   res_col;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  mmu_job_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_k_len(job_k_len), .job_base_addr(job_base_addr),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_data_in(buf_data_in), .buf_weight_in(buf_weight_in),
    .mmu_cmd_valid(mmu_cmd_valid), .mmu_cmd(mmu_cmd),
    .mmu_data_out(mmu_data_out), .mmu_weight_out(mmu_weight_out),
    .mmu_busy(mmu_busy),
    .rdata_1_in(rdata_1_in), .rdata_2_in(rdata_2_in),
    .rdata_3_in(rdata_3_in), .rdata_4_in(rdata_4_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_col(res_col),
    .done(done), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] mkdata(input logic [11:0] a);
    return {16'hDA01, 4'h0, a, 16'hDA02, 4'h0, a, 16'hDA03, 4'h0, a, 16'hDA04, 4'h0, a};
  endfunction

  function automatic logic [127:0] mkwt(input logic [11:0] a);
    return {16'hBE01, 4'h0, a, 16'hBE02, 4'h0, a, 16'hBE03, 4'h0, a, 16'hBE04, 4'h0, a};
  endfunction

  function automatic logic [127:0] col_val(input logic [7:0] seed, input int col);
    logic [31:0] v;
    v = {16'h0000, seed, 8'hC0 + 8'(col)};
    return {4{v}};
  endfunction

  // Operand buffer model: one-cycle read latency
  always @(posedge clk_i) begin
    if (buf_rd_en) begin
      buf_data_in   <= mkdata(buf_rd_addr);
      buf_weight_in <= mkwt(buf_rd_addr);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_rdata(input logic [7:0] seed);
    rdata_1_in = col_val(seed, 0);
    rdata_2_in = col_val(seed, 1);
    rdata_3_in = col_val(seed, 2);
    rdata_4_in = col_val(seed, 3);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #2;
    checks++;
    if ({job_ready, busy, done, res_valid, mmu_cmd_valid, buf_rd_en} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp %b", {job_ready, busy, done, res_valid, mmu_cmd_valid, buf_rd_en}, 6'b100000);
    end
    checks++;
    if ({mmu_cmd, buf_rd_addr, res_col, res_data, mmu_data_out, mmu_weight_out} !== '0) begin
      errors++;
      $display("FAIL reset_data got cmd %h addr %h col %0d res %h", mmu_cmd, buf_rd_addr, res_col, res_data);
    end
    step();
    rst_i = 1'b0;
  endtask

  // Full cycle-by-cycle trace of one job with res_ready=1 and mmu_busy=0
  task automatic test_job(input int k, input logic [11:0] base, input logic [7:0] seed, input string tag);
    int wait_c, kc, e_col;
    logic [11:0] a, e_addr;
    logic e_cv, e_rd, e_rv, e_done, e_ready;
    logic [8:0] e_cmd;
    logic [127:0] e_d, e_w, e_rdat;
    wait_c = (k == 0) ? 2 : 8 + k;
    step();
    job_valid = 1'b1; job_k_len = 16'(k); job_base_addr = base;
    res_ready = 1'b1; mmu_busy = 1'b0; set_rdata(seed);
    #1;
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept got %b exp 1", tag, job_ready);
    end
    for (int c = 1; c <= wait_c + 6; c++) begin
      step();
      if (c >= 2 && c <= wait_c) begin
        job_valid = 1'b1; job_k_len = 16'd5; job_base_addr = 12'h0AA;
      end else begin
        job_valid = 1'b0;
      end
      #1;
      e_cv = 1'b0; e_cmd = 9'd0; e_rd = 1'b0; e_addr = 12'h000; e_d = '0; e_w = '0;
      e_rv = 1'b0; e_col = 0; e_rdat = '0; e_done = 1'b0; e_ready = 1'b0;
      if (c == 1) begin
        e_cv = 1'b1;
        if (k != 0) begin e_rd = 1'b1; e_addr = base; end
      end else if (k != 0 && c <= 1 + k) begin
        kc = c - 2;
        e_cv = 1'b1;
        e_cmd = (kc == k - 1) ? 9'd2 : 9'd1;
        a = base + 12'(kc);
        e_d = mkdata(a); e_w = mkwt(a);
        if (kc + 1 < k) begin e_rd = 1'b1; e_addr = a + 12'd1; end
      end else if (k != 0 && c < wait_c) begin
        e_cv = 1'b1; e_cmd = 9'd8;
      end else if (c > wait_c && c <= wait_c + 4) begin
        e_rv = 1'b1; e_col = c - wait_c - 1; e_rdat = col_val(seed, e_col);
      end else if (c == wait_c + 5) begin
        e_done = 1'b1; e_ready = 1'b1;
      end else if (c == wait_c + 6) begin
        e_ready = 1'b1;
      end
      checks++;
      if ({mmu_cmd_valid, mmu_cmd, buf_rd_en, buf_rd_addr} !== {e_cv, e_cmd, e_rd, e_addr}) begin
        errors++;
        $display("FAIL %s cmd c%0d got v%b cmd %h rd %b @%h exp v%b cmd %h rd %b @%h", tag, c,
                 mmu_cmd_valid, mmu_cmd, buf_rd_en, buf_rd_addr, e_cv, e_cmd, e_rd, e_addr);
      end
      checks++;
      if ({mmu_data_out, mmu_weight_out} !== {e_d, e_w}) begin
        errors++;
        $display("FAIL %s vec c%0d got %h/%h exp %h/%h", tag, c, mmu_data_out, mmu_weight_out, e_d, e_w);
      end
      checks++;
      if ({res_valid, res_col, res_data} !== {e_rv, 2'(e_col), e_rdat}) begin
        errors++;
        $display("FAIL %s res c%0d got v%b col %0d %h exp v%b col %0d %h", tag, c,
                 res_valid, res_col, res_data, e_rv, e_col, e_rdat);
      end
      checks++;
      if ({done, job_ready, busy} !== {e_done, e_ready, ~e_ready}) begin
        errors++;
        $display("FAIL %s status c%0d got %b exp %b", tag, c, {done, job_ready, busy}, {e_done, e_ready, ~e_ready});
      end
    end
  endtask

  task automatic test_backpressure();
    int ec;
    logic [7:0] seed;
    seed = 8'h33;
    step();
    job_valid = 1'b1; job_k_len = 16'd1; job_base_addr = 12'h040;
    res_ready = 1'b0; mmu_busy = 1'b0; set_rdata(seed);
    for (int c = 1; c <= 9; c++) begin
      step();
      job_valid = 1'b0;
    end
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_wait got res_valid %b exp 0", res_valid);
    end
    ec = 0;
    for (int c = 10; c <= 25; c++) begin
      step();
      res_ready = ((c - 10) % 2) == 1;
      #1;
      if (ec < 4) begin
        checks++;
        if ({res_valid, res_col, res_data} !== {1'b1, 2'(ec), col_val(seed, ec)}) begin
          errors++;
          $display("FAIL bp_beat c%0d got v%b col %0d %h exp v1 col %0d %h", c,
                   res_valid, res_col, res_data, ec, col_val(seed, ec));
        end
        if (res_ready) ec++;
      end else begin
        checks++;
        if ({res_valid, done} !== 2'b01) begin
          errors++;
          $display("FAIL bp_end c%0d got valid/done %b exp 01", c, {res_valid, done});
        end
        break;
      end
    end
    step();
    res_ready = 1'b1;
    #1;
    checks++;
    if ({done, job_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_done_pulse got %b exp 01", {done, job_ready});
    end
  endtask

  task automatic test_busy_wait();
    logic [7:0] seed;
    seed = 8'h44;
    step();
    job_valid = 1'b1; job_k_len = 16'd1; job_base_addr = 12'h080;
    res_ready = 1'b1; mmu_busy = 1'b1; set_rdata(8'h01);
    for (int c = 1; c <= 8; c++) begin
      step();
      job_valid = 1'b0;
    end
    for (int c = 9; c <= 28; c++) begin
      step();
      set_rdata(8'(c));
      #1;
      checks++;
      if ({mmu_cmd_valid, res_valid, busy} !== 3'b001) begin
        errors++;
        $display("FAIL busy_hold c%0d got %b exp 001", c, {mmu_cmd_valid, res_valid, busy});
      end
    end
    step();
    mmu_busy = 1'b0; set_rdata(seed);
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_capture_cycle got res_valid %b exp 0", res_valid);
    end
    for (int b = 0; b < 4; b++) begin
      step();
      set_rdata(8'hFF);
      #1;
      checks++;
      if ({res_valid, res_col, res_data} !== {1'b1, 2'(b), col_val(seed, b)}) begin
        errors++;
        $display("FAIL busy_beat %0d got v%b col %0d %h exp %h", b, res_valid, res_col, res_data, col_val(seed, b));
      end
    end
    step();
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL busy_done got %b exp 1", done);
    end
  endtask

  task automatic test_reset_mid_job();
    step();
    job_valid = 1'b1; job_k_len = 16'd2; job_base_addr = 12'h020;
    res_ready = 1'b1; mmu_busy = 1'b0; set_rdata(8'h55);
    for (int c = 1; c <= 5; c++) begin
      step();
      job_valid = 1'b0;
    end
    #1;
    checks++;
    if ({mmu_cmd_valid, mmu_cmd} !== {1'b1, 9'd8}) begin
      errors++;
      $display("FAIL rst_mid_drain got %b/%h exp 1/008", mmu_cmd_valid, mmu_cmd);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({mmu_cmd_valid, mmu_cmd, job_ready, busy, res_valid, done, buf_rd_en} !== {1'b0, 9'd0, 5'b10000}) begin
      errors++;
      $display("FAIL rst_mid_async got v%b cmd %h rdy %b busy %b", mmu_cmd_valid, mmu_cmd, job_ready, busy);
    end
    step();
    rst_i = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      #1;
      checks++;
      if ({res_valid, done, job_ready, mmu_cmd_valid} !== 4'b0010) begin
        errors++;
        $display("FAIL rst_mid_idle c%0d got %b exp 0010", c, {res_valid, done, job_ready, mmu_cmd_valid});
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; job_valid = 1'b0; job_k_len = 16'd0; job_base_addr = 12'h000;
    mmu_busy = 1'b0; res_ready = 1'b0; set_rdata(8'h00);
    buf_data_in = '0; buf_weight_in = '0;
    test_reset();
    test_job(2, 12'h010, 8'h11, "k2");
    test_backpressure();
    test_busy_wait();
    test_job(0, 12'h123, 8'h22, "k0");
    test_job(3, 12'hFFF, 8'h66, "wrap");
    test_reset_mid_job();
    test_job(1, 12'h100, 8'h77, "after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
